// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation unit: FSM encoding,
// default operand widths and the per-multiply latency helper.
package rsa_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_EXP_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TO_MONT   = 3'd1,
      SQUARE    = 3'd2,
      MULT      = 3'd3,
      FROM_MONT = 3'd4,
      DONE      = 3'd5
   } state_t;

   // One Montgomery multiply: load cycle, WIDTH iterations, correction cycle.
   function automatic int mm_latency(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/rsa_mont_mult.sv
// Bit-serial Montgomery multiplier r = a*b*2^-WIDTH mod p; exactly WIDTH+2 enabled
// cycles from go to done, done is combinational in the final (correction) cycle.
module rsa_mont_mult
   import rsa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             en,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] p,
   output logic             done,
   output logic [WIDTH-1:0] r
);

   localparam int L  = mm_latency(WIDTH);
   localparam int CW = $clog2(L + 1);

   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH+1:0] sum_b, sum_p;
   logic [WIDTH-1:0] r_sub;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      done  = 1'b0;

      // Accumulator stays below 2p, so acc + b + p fits in WIDTH+2 bits.
      sum_b = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
      sum_p = sum_b[0] ? (sum_b + {2'b00, p}) : sum_b;
      r_sub = acc_q[WIDTH-1:0] - p;
      r     = (acc_q >= {2'b00, p}) ? r_sub : acc_q[WIDTH-1:0];

      if (cnt_q == CW'(L - 1)) begin
         done  = 1'b1;
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         acc_d = sum_p >> 1;
         a_d   = a_q >> 1;
         cnt_d = cnt_q + CW'(1);
      end else if (go) begin
         a_d   = a;
         b_d   = b;
         acc_d = '0;
         cnt_d = CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (en) begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rsa_mmexp_unit.sv
// Left-to-right Montgomery modular exponentiation C = M^E mod P; latency L*(3+EXP_WIDTH+popcount(E))+1
// enabled cycles, en low stalls everything. RSA_MOD_CHECK_EN adds an illegal-modulus check driving err.
module rsa_mmexp_unit
   import rsa_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 en,
   input  logic                 start,
   input  logic [WIDTH-1:0]     P,
   input  logic [EXP_WIDTH-1:0] E,
   input  logic [WIDTH-1:0]     M,
   input  logic [WIDTH-1:0]     Const,
   output logic                 busy,
   output logic                 eoc,
   output logic                 err,
   output logic [WIDTH-1:0]     C
);

   localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     p_q, p_d, m_q, m_d, k_q, k_d;
   logic [EXP_WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0]     mbar_q, mbar_d, abar_q, abar_d, c_q, c_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 sub_q, sub_d, go_q, go_d;
   logic [WIDTH-1:0]     mm_a, mm_b, mm_r;
   logic                 mm_done;
`ifdef RSA_MOD_CHECK_EN
   logic                 err_q, err_d;
`endif

   rsa_mont_mult #(.WIDTH(WIDTH)) u_mm (
      .clk  (clk),
      .rstb (rstb),
      .en   (en),
      .go   (go_q),
      .a    (mm_a),
      .b    (mm_b),
      .p    (p_q),
      .done (mm_done),
      .r    (mm_r)
   );

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      e_d     = e_q;
      m_d     = m_q;
      k_d     = k_q;
      mbar_d  = mbar_q;
      abar_d  = abar_q;
      c_d     = c_q;
      bit_d   = bit_q;
      sub_d   = sub_q;
      go_d    = 1'b0;
      mm_a    = abar_q;
      mm_b    = abar_q;
`ifdef RSA_MOD_CHECK_EN
      err_d   = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               p_d     = P;
               e_d     = E;
               m_d     = M;
               k_d     = Const;
               sub_d   = 1'b0;
               bit_d   = BW'(EXP_WIDTH - 1);
               state_d = TO_MONT;
               go_d    = 1'b1;
`ifdef RSA_MOD_CHECK_EN
               err_d   = 1'b0;
               if (!P[0] || (P < WIDTH'(3))) begin
                  state_d = DONE;
                  go_d    = 1'b0;
                  c_d     = '0;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         TO_MONT: begin
            // First pass maps M into the Montgomery domain, second builds R mod P as the running 1.
            mm_a = sub_q ? WIDTH'(1) : m_q;
            mm_b = k_q;
            if (mm_done) begin
               go_d = 1'b1;
               if (!sub_q) begin
                  mbar_d = mm_r;
                  sub_d  = 1'b1;
               end else begin
                  abar_d  = mm_r;
                  state_d = SQUARE;
               end
            end
         end
         SQUARE: begin
            if (mm_done) begin
               abar_d = mm_r;
               go_d   = 1'b1;
               if (e_q[bit_q]) begin
                  state_d = MULT;
               end else if (bit_q == '0) begin
                  state_d = FROM_MONT;
               end else begin
                  bit_d = bit_q - BW'(1);
               end
            end
         end
         MULT: begin
            mm_b = mbar_q;
            if (mm_done) begin
               abar_d = mm_r;
               go_d   = 1'b1;
               if (bit_q == '0) begin
                  state_d = FROM_MONT;
               end else begin
                  bit_d   = bit_q - BW'(1);
                  state_d = SQUARE;
               end
            end
         end
         FROM_MONT: begin
            mm_b = WIDTH'(1);
            if (mm_done) begin
               c_d     = mm_r;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         p_q     <= '0;
         e_q     <= '0;
         m_q     <= '0;
         k_q     <= '0;
         mbar_q  <= '0;
         abar_q  <= '0;
         c_q     <= '0;
         bit_q   <= '0;
         sub_q   <= 1'b0;
         go_q    <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         p_q     <= p_d;
         e_q     <= e_d;
         m_q     <= m_d;
         k_q     <= k_d;
         mbar_q  <= mbar_d;
         abar_q  <= abar_d;
         c_q     <= c_d;
         bit_q   <= bit_d;
         sub_q   <= sub_d;
         go_q    <= go_d;
      end
   end

`ifdef RSA_MOD_CHECK_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         err_q <= 1'b0;
      end else if (en) begin
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy = (state_q != IDLE);
   assign eoc  = (state_q == DONE) && en;
   assign C    = c_q;

endmodule

// File: tb/tb_rsa_mmexp_unit.sv
// Directed bench for rsa_mmexp_unit at WIDTH=8, EXP_WIDTH=8 with hand-computed results and latencies.
module tb_rsa_mmexp_unit;

   logic       clk = 1'b0;
   logic       rstb, en, start;
   logic [7:0] P, E, M, Const;
   logic       busy, eoc, err;
   logic [7:0] C;

   int n_cmp = 0;
   int n_mis = 0;

   rsa_mmexp_unit #(.WIDTH(8), .EXP_WIDTH(8)) dut (
      .clk   (clk),
      .rstb  (rstb),
      .en    (en),
      .start (start),
      .P     (P),
      .E     (E),
      .M     (M),
      .Const (Const),
      .busy  (busy),
      .eoc   (eoc),
      .err   (err),
      .C     (C)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Launch one operation, scramble the inputs after accept, and measure cycles to eoc.
   task automatic do_op(input string tag, input logic [7:0] p, input logic [7:0] k,
                        input logic [7:0] m, input logic [7:0] e, input logic [7:0] exp_c,
                        input int exp_lat, input bit gap, input bit exp_err);
      int   lat;
      int   g0;
      bit   seen;
      logic [7:0] c_seen;
      g0 = $urandom_range(20, 100);
      @(negedge clk);
      P = p; E = e; M = m; Const = k; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      P = 8'd255; E = 8'hA5; M = 8'd77; Const = 8'd3;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 3000) begin
         @(negedge clk);
         lat++;
         if (lat == 5 && exp_lat > 5) chk({tag, "_busy"}, busy, 1);
         if (eoc) begin
            seen = 1'b1;
         end else begin
            en    = !(gap && lat >= g0 && lat < g0 + 20);
            start = (lat == 10 || lat == 70);
         end
      end
      start  = 1'b0;
      en     = 1'b1;
      chk({tag, "_eoc_seen"}, seen, 1);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_C"}, C, exp_c);
      chk({tag, "_err"}, err, exp_err);
      c_seen = C;
      @(negedge clk);
      chk({tag, "_eoc_pulse"}, eoc, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_C_hold"}, C, c_seen);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n_eoc;
      rstb = 1'b0; en = 1'b1; start = 1'b0;
      P = '0; E = '0; M = '0; Const = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_eoc", eoc, 0);
      chk("rst_err", err, 0);
      chk("rst_C", C, 0);
      rstb = 1'b1;

      // L = 10; latency = 10*(3 + 8 + popcount(E)) + 1
      do_op("e7",    8'd187, 8'd86, 8'd88, 8'd7,   8'd11, 141, 1'b0, 1'b0);
      do_op("e23",   8'd187, 8'd86, 8'd11, 8'd23,  8'd88, 151, 1'b0, 1'b0);
      do_op("e0",    8'd187, 8'd86, 8'd5,  8'd0,   8'd1,  111, 1'b0, 1'b0);
      do_op("m0",    8'd187, 8'd86, 8'd0,  8'd9,   8'd0,  131, 1'b0, 1'b0);
      do_op("e1",    8'd187, 8'd86, 8'd88, 8'd1,   8'd88, 121, 1'b0, 1'b0);
      do_op("p13",   8'd13,  8'd3,  8'd2,  8'd10,  8'd10, 131, 1'b0, 1'b0);
      do_op("e255",  8'd13,  8'd3,  8'd2,  8'd255, 8'd8,  191, 1'b0, 1'b0);
      do_op("engap", 8'd187, 8'd86, 8'd88, 8'd7,   8'd11, 161, 1'b1, 1'b0);

      // Abort mid-run: outputs clear at once and the aborted operation never reports.
      @(negedge clk);
      P = 8'd187; E = 8'd7; M = 8'd88; Const = 8'd86; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (50) @(negedge clk);
      rstb = 1'b0;
      #1;
      chk("abort_C", C, 0);
      chk("abort_busy", busy, 0);
      chk("abort_eoc", eoc, 0);
      @(negedge clk);
      rstb  = 1'b1;
      n_eoc = 0;
      repeat (200) begin
         @(negedge clk);
         if (eoc) n_eoc++;
      end
      chk("abort_no_eoc", n_eoc, 0);
      do_op("after_rst", 8'd187, 8'd86, 8'd88, 8'd7, 8'd11, 141, 1'b0, 1'b0);

`ifdef RSA_MOD_CHECK_EN
      do_op("badp",  8'd186, 8'd86, 8'd88, 8'd7, 8'd0,  1,   1'b0, 1'b1);
      chk("badp_err_hold", err, 1);
      do_op("goodp", 8'd187, 8'd86, 8'd88, 8'd7, 8'd11, 141, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
